// File: rtl/sp_ram_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_stream_ctrl
// Description : Stream-side controller for a single-port RAM. A write
//               command moves a valid/ready input stream into consecutive RAM
//               words. A read command streams consecutive RAM words out over
//               valid/ready with full backpressure. The RAM's one-cycle read
//               latency is absorbed by a 2-entry output FIFO.
//
// Ports
//   clk, nreset                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_rd, cmd_base, cmd_len       direction, first address, word count
//   s_valid/s_ready/s_data          write-data stream (sink)
//   m_valid/m_ready/m_data/m_last   read-data stream (source)
//   ram_re, ram_we, ram_addr,
//   ram_din, ram_dout               single-port RAM interface
//   busy, done, err                 status; done/err are one-cycle pulses
//
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_stream_ctrl #(
    parameter int RAM_DEEP = 40,
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = $clog2(RAM_DEEP),
    parameter int LWIDTH   = $clog2(RAM_DEEP + 1)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rd,
    input  logic [AWIDTH-1:0] cmd_base,
    input  logic [LWIDTH-1:0] cmd_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic              ram_re,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    input  logic [DWIDTH-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Base limit is one bit wider so a power-of-two depth does not truncate.
    localparam logic [AWIDTH:0]   BASE_LIMIT = (AWIDTH + 1)'(RAM_DEEP);
    localparam logic [LWIDTH-1:0] LEN_MAX    = LWIDTH'(RAM_DEEP);
    localparam logic [AWIDTH-1:0] PTR_LAST   = AWIDTH'(RAM_DEEP - 1);
    localparam logic [AWIDTH-1:0] PTR_ONE    = AWIDTH'(1);
    localparam logic [LWIDTH-1:0] LEN_ONE    = LWIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t            state;
    logic [AWIDTH-1:0] ptr;          // next RAM address to access
    logic [LWIDTH-1:0] remaining;    // RAM accesses still to issue
    logic [LWIDTH-1:0] out_left;     // read words still to hand out
    logic              inflight;     // ram_re of the previous cycle
    logic [DWIDTH-1:0] fifo_mem [2];
    logic              fifo_rd_idx;
    logic              fifo_wr_idx;
    logic [1:0]        fifo_count;
    logic              done_q;
    logic              err_q;

    logic              cmd_fire;
    logic              base_bad;
    logic [LWIDTH-1:0] eff_len;
    logic [AWIDTH-1:0] ptr_next;
    logic              pop;
    logic              wr_beat;
    logic              rd_issue;
    logic [2:0]        occupancy;

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        cmd_fire  = cmd_valid & cmd_ready;
        base_bad  = ({1'b0, cmd_base} >= BASE_LIMIT);
        eff_len   = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
        ptr_next  = (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;

        m_valid   = (fifo_count != 2'd0);
        // Head is forced to zero when empty so stale words never leak out.
        m_data    = m_valid ? fifo_mem[fifo_rd_idx] : '0;
        m_last    = m_valid && (out_left == LEN_ONE);
        pop       = m_valid & m_ready;

        // Words already committed to the FIFO after this cycle's pop; a new
        // read is only issued when a slot is guaranteed for its data.
        occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

        s_ready   = (state == ST_WRITE);
        wr_beat   = s_ready & s_valid;
        rd_issue  = (state == ST_READ) && (remaining != '0) && (occupancy < 3'd2);

        ram_we    = wr_beat;
        ram_re    = rd_issue;
        ram_addr  = (state == ST_IDLE) ? '0 : ptr;
        ram_din   = (state == ST_WRITE) ? s_data : '0;

        busy      = (state != ST_IDLE);
        done      = done_q;
        err       = err_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            remaining   <= '0;
            out_left    <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_rd_idx <= 1'b0;
            fifo_wr_idx <= 1'b0;
            fifo_count  <= 2'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            inflight <= rd_issue;

            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (base_bad) begin
                            err_q <= 1'b1;
                        end else if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            ptr       <= cmd_base;
                            remaining <= eff_len;
                            out_left  <= eff_len;
                            state     <= cmd_rd ? ST_READ : ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_beat) begin
                        ptr       <= ptr_next;
                        remaining <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_issue) begin
                        ptr       <= ptr_next;
                        remaining <= remaining - LEN_ONE;
                    end
                    if (pop) begin
                        out_left <= out_left - LEN_ONE;
                        if (out_left == LEN_ONE) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Registered RAM data arrives the cycle after ram_re.
            if (inflight) begin
                fifo_mem[fifo_wr_idx] <= ram_dout;
                fifo_wr_idx           <= ~fifo_wr_idx;
            end
            if (pop) begin
                fifo_rd_idx <= ~fifo_rd_idx;
            end
            case ({inflight, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_stream_ctrl
// Description : Self-checking bench for sp_ram_stream_ctrl. A behavioural RAM
//               sits on the RAM port; an address-indexed reference memory
//               holds what each write command should have stored, and read
//               results are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sp_ram_stream_ctrl;

    localparam int DEEP = 40;
    localparam int DW   = 16;
    localparam int AW   = 6;
    localparam int LW   = 6;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_rd = 1'b0;
    logic [AW-1:0] cmd_base = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          ram_re;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    sp_ram_stream_ctrl #(.RAM_DEEP(DEEP), .DWIDTH(DW)) dut (
        .clk(clk), .nreset(nreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .done(done), .err(err)
    );

    // Behavioural single-port RAM: registered read, dout is 0 when re is low.
    logic [DW-1:0] ram [DEEP];
    always @(posedge clk) begin
        if (ram_we && int'(ram_addr) < DEEP) ram[ram_addr] <= ram_din;
        ram_dout <= (ram_re && int'(ram_addr) < DEEP) ? ram[ram_addr] : '0;
    end

    // Reference contents: what the commanded writes should leave at each address.
    logic [DW-1:0] ref_mem [DEEP];

    int checks = 0;
    int errors = 0;

    // Bus monitor: pulse counters, address log and buffer-overflow watch.
    int done_cnt = 0, err_cnt = 0, strobe_cnt = 0, viol = 0;
    int issued = 0, popped = 0;
    int addr_log[$];
    always @(negedge clk) begin
        if (!nreset) begin
            issued <= 0;
            popped <= 0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (err)  err_cnt  <= err_cnt + 1;
            if (ram_re || ram_we) begin
                strobe_cnt <= strobe_cnt + 1;
                addr_log.push_back(int'(ram_addr));
            end
            // Words outstanding = issued reads not yet handed out.
            if ((ram_re || ram_we) && int'(ram_addr) >= DEEP) viol <= viol + 1;
            if (!busy && (ram_re || ram_we)) viol <= viol + 1;
            if (ram_re && (issued - popped - ((m_valid && m_ready) ? 1 : 0)) >= 2)
                viol <= viol + 1;
            if (ram_re) issued <= issued + 1;
            if (m_valid && m_ready) popped <= popped + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (collect results; comparisons live in the tests)
    // ------------------------------------------------------------------
    logic [DW-1:0] wdata[$];
    logic [DW-1:0] got_data[$];
    bit            got_last[$];
    int            rb_first, rb_gaps, wb_bad;
    bit            rb_done_ok, wb_done_ok;

    task automatic issue_cmd(input bit rd, input int base, input int len);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_base  = AW'(base);
        cmd_len   = LW'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input int base, input int len, input bit bubbles);
        int eff, i, guard;
        bit beat;
        eff = (len > DEEP) ? DEEP : len;
        i = 0; guard = 0; wb_bad = 0; wb_done_ok = 1'b0;
        issue_cmd(1'b0, base, len);
        while (i < eff && guard < 2000) begin
            s_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = wdata[i];
            @(negedge clk);
            beat = s_valid && s_ready;
            if (s_valid && (ram_we !== 1'b1 || ram_din !== s_data ||
                            int'(ram_addr) != (base + i) % DEEP)) wb_bad++;
            @(posedge clk); #1;
            if (beat) begin
                ref_mem[(base + i) % DEEP] = wdata[i];
                i++;
            end
            guard++;
        end
        s_valid = 1'b0;
        @(negedge clk);
        wb_done_ok = done && cmd_ready && !busy;
        @(posedge clk); #1;
    endtask

    task automatic read_burst(input int base, input int len, input bit rand_ready);
        int eff, cyc;
        eff = (len > DEEP) ? DEEP : len;
        got_data.delete(); got_last.delete();
        rb_first = -1; rb_gaps = 0; rb_done_ok = 1'b0;
        issue_cmd(1'b1, base, len);
        cyc = 1;
        while (got_data.size() < eff && cyc < 2000) begin
            m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (m_valid && rb_first < 0) rb_first = cyc;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
            end else if (!rand_ready && rb_first >= 0) begin
                rb_gaps++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b0;
        @(negedge clk);
        rb_done_ok = done && cmd_ready && !busy;
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, m_valid, m_last, busy, done, err, ram_re, ram_we, s_ready} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100000000", {cmd_ready, m_valid, m_last, busy, done, err, ram_re, ram_we, s_ready});
        end
        checks++;
        if (m_data !== '0 || ram_addr !== '0 || ram_din !== '0) begin
            errors++;
            $display("FAIL reset_buses: m_data=%h ram_addr=%0d ram_din=%h expected all 0", m_data, ram_addr, ram_din);
        end
        #2 nreset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_sequential();
        int d0;
        wdata.delete();
        for (int i = 0; i < DEEP; i++) wdata.push_back(DW'(16'h1000 + i));
        d0 = done_cnt;
        write_burst(0, DEEP, 1'b0);
        checks++;
        if (!wb_done_ok || wb_bad != 0 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL seq_write: done_ok=%b bad_beats=%0d dones=%0d expected 1/0/1", wb_done_ok, wb_bad, done_cnt - d0);
        end
        d0 = done_cnt;
        read_burst(0, DEEP, 1'b0);
        checks++;
        if (got_data.size() != DEEP || rb_gaps != 0 || !rb_done_ok || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL seq_read: words=%0d gaps=%0d done_ok=%b dones=%0d expected %0d/0/1/1", got_data.size(), rb_gaps, rb_done_ok, done_cnt - d0, DEEP);
        end
        checks++;
        if (rb_first < 1 || rb_first > 3) begin
            errors++;
            $display("FAIL seq_first_valid: cycle %0d expected 1..3", rb_first);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== DW'(16'h1000 + i) || got_last[i] !== (i == DEEP - 1)) begin
                errors++;
                $display("FAIL seq_word%0d: data=%h last=%b expected %h/%b", i, got_data[i], got_last[i], 16'h1000 + i, i == DEEP - 1);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_addr[4];
        exp_addr = '{38, 39, 0, 1};
        wdata.delete();
        for (int i = 0; i < 4; i++) wdata.push_back(DW'($urandom));
        addr_log.delete();
        write_burst(38, 4, 1'b1);
        checks++;
        if (addr_log.size() != 4 || !wb_done_ok || wb_bad != 0) begin
            errors++;
            $display("FAIL wrap_write: strobes=%0d done_ok=%b bad=%0d expected 4/1/0", addr_log.size(), wb_done_ok, wb_bad);
        end
        for (int i = 0; i < addr_log.size() && i < 4; i++) begin
            checks++;
            if (addr_log[i] != exp_addr[i]) begin
                errors++;
                $display("FAIL wrap_waddr%0d: got %0d expected %0d", i, addr_log[i], exp_addr[i]);
            end
        end
        addr_log.delete();
        read_burst(38, 4, 1'b0);
        checks++;
        if (got_data.size() != 4 || addr_log.size() != 4) begin
            errors++;
            $display("FAIL wrap_read_count: words=%0d strobes=%0d expected 4/4", got_data.size(), addr_log.size());
        end
        for (int i = 0; i < got_data.size() && i < addr_log.size() && i < 4; i++) begin
            checks++;
            if (got_data[i] !== wdata[i] || addr_log[i] != exp_addr[i]) begin
                errors++;
                $display("FAIL wrap_rd%0d: data=%h addr=%0d expected %h/%0d", i, got_data[i], addr_log[i], wdata[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int v0, base;
        v0 = viol;
        base = int'($urandom_range(0, DEEP - 1));
        read_burst(base, 10, 1'b1);
        checks++;
        if (got_data.size() != 10 || !rb_done_ok || viol != v0) begin
            errors++;
            $display("FAIL bp_summary: words=%0d done_ok=%b violations=%0d expected 10/1/0", got_data.size(), rb_done_ok, viol - v0);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== ref_mem[(base + i) % DEEP] || got_last[i] !== (i == 9)) begin
                errors++;
                $display("FAIL bp_word%0d: data=%h last=%b expected %h/%b", i, got_data[i], got_last[i], ref_mem[(base + i) % DEEP], i == 9);
            end
        end
    endtask

    task automatic test_boundary();
        int s0;
        s0 = strobe_cnt;
        issue_cmd(1'b1, 3, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL len0: done=%b err=%b busy=%b cmd_ready=%b expected 1/0/0/1", done, err, busy, cmd_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (strobe_cnt != s0 || done !== 1'b0) begin
            errors++;
            $display("FAIL len0_no_strobe: strobes=%0d done=%b expected 0/0", strobe_cnt - s0, done);
        end
        issue_cmd(1'b0, DEEP, 5);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_base: err=%b done=%b busy=%b cmd_ready=%b expected 1/0/0/1", err, done, busy, cmd_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || strobe_cnt != s0) begin
            errors++;
            $display("FAIL bad_base_idle: err=%b busy=%b s_ready=%b strobes=%0d expected 0/0/0/0", err, busy, s_ready, strobe_cnt - s0);
        end
        read_burst(5, 63, 1'b0);
        checks++;
        if (got_data.size() != DEEP || !rb_done_ok || got_last[DEEP - 1] !== 1'b1) begin
            errors++;
            $display("FAIL len_sat: words=%0d done_ok=%b expected %0d/1 with final m_last", got_data.size(), rb_done_ok, DEEP);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== ref_mem[(5 + i) % DEEP]) begin
                errors++;
                $display("FAIL len_sat_word%0d: got %h expected %h", i, got_data[i], ref_mem[(5 + i) % DEEP]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int n, guard, d0;
        issue_cmd(1'b1, 0, 20);
        m_ready = 1'b1;
        n = 0; guard = 0;
        while (n < 4 && guard < 200) begin
            @(negedge clk);
            if (m_valid && m_ready) n++;
            @(posedge clk); #1;
            guard++;
        end
        m_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrd_word5: m_valid=%b busy=%b expected 1/1", m_valid, busy);
        end
        d0 = done_cnt;
        #2 nreset = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || ram_re !== 1'b0) begin
            errors++;
            $display("FAIL midrd_abort: m_valid=%b cmd_ready=%b busy=%b ram_re=%b expected 0/1/0/0", m_valid, cmd_ready, busy, ram_re);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 nreset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL midrd_no_done: dones=%0d expected 0", done_cnt - d0);
        end
        read_burst(0, DEEP, 1'b1);
        checks++;
        if (got_data.size() != DEEP || !rb_done_ok) begin
            errors++;
            $display("FAIL midrd_reread: words=%0d done_ok=%b expected %0d/1", got_data.size(), rb_done_ok, DEEP);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL midrd_word%0d: got %h expected %h", i, got_data[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base, len, eff;
        for (int k = 0; k < 8; k++) begin
            base = int'($urandom_range(0, DEEP - 1));
            len  = int'($urandom_range(1, 45));
            eff  = (len > DEEP) ? DEEP : len;
            if ((k % 2) == 0) begin
                wdata.delete();
                for (int i = 0; i < eff; i++) wdata.push_back(DW'($urandom));
                write_burst(base, len, 1'b1);
                checks++;
                if (!wb_done_ok || wb_bad != 0) begin
                    errors++;
                    $display("FAIL b2b_write%0d: done_ok=%b bad=%0d expected 1/0", k, wb_done_ok, wb_bad);
                end
            end else begin
                read_burst(base, len, 1'b1);
                checks++;
                if (got_data.size() != eff || !rb_done_ok) begin
                    errors++;
                    $display("FAIL b2b_read%0d: words=%0d done_ok=%b expected %0d/1", k, got_data.size(), rb_done_ok, eff);
                end
                for (int i = 0; i < got_data.size(); i++) begin
                    checks++;
                    if (got_data[i] !== ref_mem[(base + i) % DEEP] || got_last[i] !== (i == eff - 1)) begin
                        errors++;
                        $display("FAIL b2b_rd%0d_w%0d: data=%h last=%b expected %h/%b", k, i, got_data[i], got_last[i], ref_mem[(base + i) % DEEP], i == eff - 1);
                    end
                end
            end
        end
        checks++;
        if (viol != 0 || err_cnt != 1) begin
            errors++;
            $display("FAIL bus_rules: violations=%0d err_pulses=%0d expected 0/1", viol, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_backpressure();
        test_boundary();
        test_reset_mid_read();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
